// File: rtl/platform_tile_reader.sv
// Platform tile ROM read engine: maps DrawX/DrawY to a tile address across REPEAT_X copies
// and realigns ROM colour with coverage. Optional macro PLAT_TRANSPARENT_EN makes palette index 0 transparent.
module platform_tile_reader #(
  parameter int unsigned TILE_W   = 47,
  parameter int unsigned TILE_H   = 38,
  parameter int unsigned REPEAT_X = 4,
  parameter logic [9:0]  X0       = 10'd100,
  parameter logic [9:0]  Y0       = 10'd400
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_start,
  input  logic [9:0]  plat_x_in,
  input  logic [9:0]  plat_y_in,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        pixel_valid,
  output logic [10:0] tile_address,
  input  logic [3:0]  tile_index_in,
  input  logic [7:0]  tile_r_in,
  input  logic [7:0]  tile_g_in,
  input  logic [7:0]  tile_b_in,
  output logic        is_platform,
  output logic [7:0]  Plat_R,
  output logic [7:0]  Plat_G,
  output logic [7:0]  Plat_B
);

  localparam logic [5:0]  COL_LAST = 6'(TILE_W - 1);
  localparam logic [3:0]  REP_END  = 4'(REPEAT_X);
  localparam logic [9:0]  TILE_H_V = 10'(TILE_H);
  localparam logic [10:0] TILE_W_A = 11'(TILE_W);

  logic [9:0]  px_q, px_d, py_q, py_d;
  logic [5:0]  col_q, col_d;
  logic [3:0]  rep_q, rep_d;
  logic [10:0] tile_address_q, tile_address_d;
  logic        hit1_q, hit1_d, hit2_q, hit2_d;
  logic        is_platform_q, is_platform_d;
  logic [23:0] rgb_q, rgb_d;

  logic [9:0]  ry_s;
  logic        row_in_s, col_in_s, start_s, hit_s, opaque_s;
  logic [5:0]  cur_col_s;
  logic [3:0]  cur_rep_s;
  logic [10:0] addr_s;

`ifdef PLAT_TRANSPARENT_EN
  assign opaque_s = (tile_index_in != 4'h0);
`else
  logic unused_index_s;
  assign unused_index_s = ^tile_index_in;
  assign opaque_s       = 1'b1;
`endif

  // Position shadow, column counters and stage 1 address/hit generation
  always_comb begin
    px_d = px_q;
    py_d = py_q;
    if (frame_start) begin
      px_d = plat_x_in;
      py_d = plat_y_in;
    end else begin
      px_d = px_q;
      py_d = py_q;
    end

    ry_s     = DrawY - py_q;
    row_in_s = (DrawY >= py_q) && (ry_s < TILE_H_V);
    start_s  = pixel_valid && (DrawX == px_q);

    // A new line (DrawX back at 0) parks the counters until px is seen again
    if (start_s) begin
      cur_col_s = 6'd0;
      cur_rep_s = 4'd0;
    end else if (pixel_valid && (DrawX == 10'd0)) begin
      cur_col_s = 6'd0;
      cur_rep_s = REP_END;
    end else begin
      cur_col_s = col_q;
      cur_rep_s = rep_q;
    end

    col_in_s = (cur_rep_s != REP_END);
    hit_s    = pixel_valid && row_in_s && col_in_s;

    col_d = col_q;
    rep_d = rep_q;
    if (pixel_valid) begin
      if (!col_in_s) begin
        col_d = 6'd0;
        rep_d = REP_END;
      end else if (cur_col_s == COL_LAST) begin
        col_d = 6'd0;
        rep_d = cur_rep_s + 4'd1;
      end else begin
        col_d = cur_col_s + 6'd1;
        rep_d = cur_rep_s;
      end
    end else begin
      col_d = col_q;
      rep_d = rep_q;
    end

    addr_s         = 11'(ry_s) * TILE_W_A + 11'(cur_col_s);
    tile_address_d = hit_s ? addr_s : 11'd0;
    hit1_d         = hit_s;
  end

  // Stages 2 and 3: wait out ROM latency, then merge coverage with ROM colour
  always_comb begin
    hit2_d        = hit1_q;
    is_platform_d = hit2_q && opaque_s;
    if (is_platform_d) begin
      rgb_d = {tile_r_in, tile_g_in, tile_b_in};
    end else begin
      rgb_d = 24'd0;
    end
  end

  // State and pipeline registers
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      px_q           <= X0;
      py_q           <= Y0;
      col_q          <= 6'd0;
      rep_q          <= REP_END;
      tile_address_q <= 11'd0;
      hit1_q         <= 1'b0;
      hit2_q         <= 1'b0;
      is_platform_q  <= 1'b0;
      rgb_q          <= 24'd0;
    end else begin
      px_q           <= px_d;
      py_q           <= py_d;
      col_q          <= col_d;
      rep_q          <= rep_d;
      tile_address_q <= tile_address_d;
      hit1_q         <= hit1_d;
      hit2_q         <= hit2_d;
      is_platform_q  <= is_platform_d;
      rgb_q          <= rgb_d;
    end
  end

  assign tile_address = tile_address_q;
  assign is_platform  = is_platform_q;
  assign Plat_R       = rgb_q[23:16];
  assign Plat_G       = rgb_q[15:8];
  assign Plat_B       = rgb_q[7:0];

endmodule

// File: tb/tb_platform_tile_reader.sv
// Scoreboard bench for platform_tile_reader: stimulus pushes expected address/pixel,
// a monitor pops and compares at the fixed 1- and 3-cycle latencies.
module tb_platform_tile_reader;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        frame_start;
  logic [9:0]  plat_x_in, plat_y_in, DrawX, DrawY;
  logic        pixel_valid;
  logic [10:0] tile_address;
  logic [3:0]  tile_index_in;
  logic [7:0]  tile_r_in, tile_g_in, tile_b_in;
  logic        is_platform;
  logic [7:0]  Plat_R, Plat_G, Plat_B;

  always #5 Clk = ~Clk;

  platform_tile_reader dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
    .plat_x_in(plat_x_in), .plat_y_in(plat_y_in),
    .DrawX(DrawX), .DrawY(DrawY), .pixel_valid(pixel_valid),
    .tile_address(tile_address), .tile_index_in(tile_index_in),
    .tile_r_in(tile_r_in), .tile_g_in(tile_g_in), .tile_b_in(tile_b_in),
    .is_platform(is_platform), .Plat_R(Plat_R), .Plat_G(Plat_G), .Plat_B(Plat_B)
  );

  // Tile ROM model: address 50 holds the transparent (index 0, black) texel
  function automatic logic [3:0] rom_idx(input logic [10:0] a);
    return (a == 11'd50) ? 4'h0 : {a[3:1], 1'b1};
  endfunction

  function automatic logic [23:0] rom_rgb(input logic [10:0] a);
    return (rom_idx(a) == 4'h0) ? 24'd0 : {a[7:0], ~a[7:0], a[10:3]};
  endfunction

  logic [10:0] rom_addr_r;
  always @(posedge Clk) rom_addr_r <= tile_address;
  assign tile_index_in = rom_idx(rom_addr_r);
  assign {tile_r_in, tile_g_in, tile_b_in} = rom_rgb(rom_addr_r);

  int checks = 0;
  int errors = 0;
  logic [10:0] exp_addr_q[$];
  logic [24:0] exp_out_q[$];
  logic        issued = 1'b0;
  logic [2:0]  sh;

  // Reference position model (spec semantics, division-based column)
  int pxm, pym, start_x, pin_x;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) sh <= 3'b000;
    else          sh <= {sh[1:0], issued};
  end

  // Monitor: address one edge after issue, pixel three edges after issue
  always @(negedge Clk) begin
    if (Reset_n === 1'b1) begin
      if (sh[0]) begin
        if (exp_addr_q.size() == 0) begin
          errors++;
          $display("FAIL addr_queue_empty at %0t", $time);
        end else begin
          logic [10:0] ea;
          ea = exp_addr_q.pop_front();
          checks++;
          if (tile_address !== ea) begin
            errors++;
            $display("FAIL tile_address got=%0d exp=%0d at %0t", tile_address, ea, $time);
          end
        end
      end
      if (sh[2]) begin
        if (exp_out_q.size() == 0) begin
          errors++;
          $display("FAIL out_queue_empty at %0t", $time);
        end else begin
          logic [24:0] eo;
          eo = exp_out_q.pop_front();
          checks++;
          if ({is_platform, Plat_R, Plat_G, Plat_B} !== eo) begin
            errors++;
            $display("FAIL pixel got plat=%0b rgb=%02h%02h%02h exp plat=%0b rgb=%06h at %0t",
                     is_platform, Plat_R, Plat_G, Plat_B, eo[24], eo[23:0], $time);
          end
        end
      end
    end
  end

  task automatic pix(input logic v, input int x, input int y, input logic fs);
    int dx;
    logic hit, plat;
    logic [10:0] a;
    @(negedge Clk);
    pixel_valid = v;
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    frame_start = fs;
    plat_x_in   = 10'(pin_x);
    plat_y_in   = 10'd400;
    issued      = 1'b1;
    if (v && (x == pxm)) start_x = x;
    dx  = x - start_x;
    hit = v && (start_x >= 0) && (dx < 188) && (y >= pym) && (y < pym + 38);
    a   = hit ? 11'((y - pym) * 47 + (dx % 47)) : 11'd0;
    plat = hit;
`ifdef PLAT_TRANSPARENT_EN
    plat = hit && (rom_idx(a) != 4'h0);
`endif
    exp_addr_q.push_back(a);
    exp_out_q.push_back({plat, plat ? rom_rgb(a) : 24'd0});
    if (fs) pxm = pin_x;
  endtask

  task automatic line(input int y, input int x1, input int fs_x);
    start_x = -1;
    for (int x = 0; x <= x1; x++) pix(1'b1, x, y, x == fs_x);
    repeat (4) pix(1'b0, 640, y, 1'b0);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if ({tile_address, is_platform, Plat_R, Plat_G, Plat_B} !== 36'd0) begin
      errors++;
      $display("FAIL %s got addr=%0d plat=%0b rgb=%02h%02h%02h exp all zero",
               name, tile_address, is_platform, Plat_R, Plat_G, Plat_B);
    end
  endtask

  initial begin
    Reset_n = 1'b0; frame_start = 1'b0; pixel_valid = 1'b0;
    DrawX = 10'd0; DrawY = 10'd0; plat_x_in = 10'd0; plat_y_in = 10'd0;
    pxm = 100; pym = 400; start_x = -1; pin_x = 100;
    repeat (3) @(negedge Clk);
    check_zero("reset_outputs");
    Reset_n = 1'b1;

    // First pixel, boundaries, column wrap and transparent texel at address 50
    line(400, 300, -1);
    line(399, 300, -1);
    line(401, 300, -1);
    line(437, 300, -1);
    line(438, 300, -1);

    // Requested position ignored until frame_start
    pin_x = 200;
    line(401, 399, -1);
    pix(1'b0, 640, 500, 1'b1);
    line(401, 399, -1);

    // frame_start on an active pixel: that pixel still uses the old px (200)
    pin_x = 100;
    line(401, 399, 200);
    line(401, 399, -1);

    // Platform running off the right edge does not wrap into the next line
    pin_x = 500;
    pix(1'b0, 640, 500, 1'b1);
    line(401, 639, -1);
    line(402, 639, -1);

    // Asynchronous reset in the middle of covered pixels
    start_x = -1;
    for (int x = 0; x <= 520; x++) pix(1'b1, x, 402, 1'b0);
    @(posedge Clk);
    #2;
    Reset_n = 1'b0;
    issued  = 1'b0;
    #1;
    check_zero("async_reset_midline");
    exp_addr_q.delete();
    exp_out_q.delete();
    pxm = 100; pym = 400;
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    line(401, 300, -1);

    @(negedge Clk);
    issued = 1'b0;
    repeat (6) @(negedge Clk);
    checks++;
    if ((exp_addr_q.size() != 0) || (exp_out_q.size() != 0)) begin
      errors++;
      $display("FAIL drain got addr_left=%0d out_left=%0d exp 0", exp_addr_q.size(), exp_out_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/platform_tile_reader.md
# platform_tile_reader

Read-side engine for the platform tile ROM. It converts the VGA controller's current pixel coordinate into an 11-bit tile ROM address and drives the platform across REPEAT_X side-by-side copies of the tile. It realigns the ROM's 1-cycle palette/RGB result with its own in-bounds flag and presents one registered pixel (colour plus coverage flag) to the colour mapper. It sits between the VGA controller, the tile ROM and the colour mapper.

## Interface
Parameters:
- TILE_W, 47, tile width in pixels
- TILE_H, 38, tile height in rows (TILE_W*TILE_H ≤ 2048; default spans addresses 0..1785)
- REPEAT_X, 4, number of horizontal tile copies (1..15)
- X0, 10'd100, platform left edge used after reset until the first frame_start
- Y0, 10'd400, platform top edge used after reset until the first frame_start

Ports:
- Clk  in  1  pixel clock; all state on the rising edge
- Reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at vertical sync; latches plat_x_in/plat_y_in
- plat_x_in  in  10  requested platform left edge
- plat_y_in  in  10  requested platform top edge
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- pixel_valid  in  1  high while DrawX/DrawY are in the active area
- tile_address  out  11  ROM address, registered
- tile_index_in  in  4  palette index from ROM, valid 1 cycle after tile_address
- tile_r_in, tile_g_in, tile_b_in  in  8 each  palette RGB from ROM, aligned with tile_index_in
- is_platform  out  1  pixel is covered by the platform
- Plat_R, Plat_G, Plat_B  out  8 each  platform colour; 0 when is_platform=0

## Operation
- Shadow registers px/py hold the platform position.
  - Reset loads X0/Y0.
  - frame_start loads plat_x_in/plat_y_in. Position therefore changes only between frames, which prevents tearing.
- Row offset: ry = DrawY − py (10-bit). The row is in range when DrawY ≥ py and ry < TILE_H.
- Column tracking uses counters, not division:
  - col (6-bit) and rep (4-bit) both clear when pixel_valid and DrawX == px.
  - Each following valid pixel increments col.
  - When col == TILE_W−1, col wraps to 0 and rep increments.
  - Coverage ends when rep == REPEAT_X. Counters saturate there until the next DrawX == px.
- Column is in range from DrawX == px until rep reaches REPEAT_X. If DrawX restarts at 0, no coverage occurs until px is seen again.
- Stage 1 registers:
  - tile_address ← ry*TILE_W + col. Computed with 11-bit arithmetic; the product is truncated to 11 bits.
  - hit1 ← pixel_valid & row-in-range & column-in-range.
- Outside the platform, tile_address holds 0.
- Stage 2 (ROM latency) registers hit2 ← hit1.
- Stage 3 (output register):
  - is_platform ← hit2 & opaque.
  - Plat_RGB ← is_platform ? tile_rgb : 0.
- Platform extends past right edge (px + REPEAT_X*TILE_W > 639): pixels beyond column 639 are simply never drawn. There is no wrap to the left side.
- frame_start coincident with an active pixel: the new position takes effect on the next cycle. The current pixel uses the old position.

## Timing
- Latency is 3 cycles from DrawX/DrawY at edge n to is_platform/Plat_RGB at edge n+3.
  - tile_address is valid after edge n+1.
  - ROM data is sampled at edge n+3.
- Throughput: one pixel per clock, no stalls.
- Reset is asynchronous.
  - All outputs reset to 0: tile_address=0, is_platform=0, Plat_R/G/B=0.
  - hit1 and hit2 reset to 0.
  - col=0, rep=REPEAT_X (idle).
  - px=X0, py=Y0.
- Reset_n asserted mid-line clears the pipeline immediately. The first covered pixel after release appears 3 cycles after the next DrawX == px inside a row in range.

## Configuration
- PLAT_TRANSPARENT_EN
  - Defined: palette index 4'h0 is transparent; opaque = (tile_index_in != 0). Index-0 pixels give is_platform=0 and RGB=0.
  - Undefined: opaque = 1, so every in-range pixel sets is_platform=1, including black index-0 pixels.

## Test plan
- Reset then idle: Reset_n low mid-pixel stream -> all outputs 0 asynchronously. After release, px=100 and py=400 are in effect.
- First pixel: DrawX=100, DrawY=400 -> tile_address=0 one cycle later. is_platform=1 and Plat_RGB = ROM RGB 3 cycles later (index≠0).
- Wrap: DrawY=401, DrawX=146 then 147 -> addresses 47+46=93, then 47+0=47 (rep=1). At DrawX=288 (rep=4) -> is_platform=0.
- Frame latch: plat_x_in=200 without frame_start -> coverage still starts at DrawX=100. After a frame_start pulse -> coverage starts at DrawX=200, and DrawX=100 gives is_platform=0.
- Boundaries: DrawY=399 and DrawY=438 -> is_platform=0. DrawY=437, DrawX=100 -> tile_address=1739.
- Transparency: ROM returns index 0 on a covered pixel -> with PLAT_TRANSPARENT_EN, is_platform=0 and RGB=0. Without it, is_platform=1 and RGB=00/00/00.
